// File: rtl/s2p_onehot_rx.sv
// s2p_onehot_rx: oversampling two-wire (scl/sda) start/stop framed receiver.
// Shifts in a DATA_W-bit code MSB first and decodes it on a valid stop to a
// 2**DATA_W one-hot word: code v sets bit (v-1) mod 2**DATA_W.
// Optional build macro S2P_PARITY_EN adds one even-parity bit after the data.
module s2p_onehot_rx #(
  parameter int DATA_W      = 4,
  parameter int SYNC_STAGES = 2,
  localparam int OUT_W      = 2**DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl,
  input  logic             sda,
  output logic [OUT_W-1:0] out_onehot,
  output logic             valid,
  output logic             frame_err,
  output logic             busy
);

`ifdef S2P_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int CNT_W = $clog2(NBITS + 1);

  typedef enum logic [1:0] {IDLE, DATA, WAIT_STOP} state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_s, sda_s, scl_d, sda_d;
  logic                   start_ev, stop_ev, bit_ev;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [NBITS-1:0]       shreg, shreg_n;
  logic [OUT_W-1:0]       out_n;
  logic                   valid_n, ferr_n;
  logic [DATA_W-1:0]      code, idx;
  logic [OUT_W-1:0]       decoded;
  logic                   par_ok;

  // Synchronisers plus one history stage; reset to the idle bus level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Start/stop need scl stable high, so a simultaneous scl change always
  // leaves only the bit event.
  assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;
  assign bit_ev   = scl_s & ~scl_d;

  assign code    = shreg[NBITS-1 -: DATA_W];
  assign idx     = code - DATA_W'(1);
  assign decoded = {{(OUT_W-1){1'b0}}, 1'b1} << idx;

`ifdef S2P_PARITY_EN
  assign par_ok = ~^shreg;
`else
  assign par_ok = 1'b1;
`endif

  assign busy = (state != IDLE);

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      out_onehot <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      out_onehot <= out_n;
      valid      <= valid_n;
      frame_err  <= ferr_n;
    end
  end

  // Next-state, shift/count and pulse generation.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    out_n   = out_onehot;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start_ev) begin
          state_n = DATA;
          cnt_n   = '0;
          shreg_n = '0;
        end
      end
      DATA: begin
        if (bit_ev) begin
          // Shift the level held before the rising scl, so sda may move
          // together with that edge (needed to reach a stop after a 1 bit).
          shreg_n = {shreg[NBITS-2:0], sda_d};
          cnt_n   = cnt + CNT_W'(1);
          if (cnt_n == CNT_W'(NBITS)) state_n = WAIT_STOP;
        end else if (stop_ev) begin
          ferr_n  = 1'b1;
          state_n = IDLE;
        end else if (start_ev) begin
          cnt_n   = '0;
          shreg_n = '0;
        end
      end
      WAIT_STOP: begin
        if (stop_ev) begin
          if (par_ok) begin
            out_n   = decoded;
            valid_n = 1'b1;
          end else begin
            ferr_n  = 1'b1;
          end
          state_n = IDLE;
        end else if (bit_ev) begin
          ferr_n  = 1'b1;
          state_n = IDLE;
        end else if (start_ev) begin
          state_n = DATA;
          cnt_n   = '0;
          shreg_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_s2p_onehot_rx.sv
// Bench for s2p_onehot_rx: table-driven frames on a DATA_W=4 instance, plus
// hand-written repeated-start, mid-frame reset and DATA_W=6 latency cases.
// Honours S2P_PARITY_EN by appending the even-parity bit to each frame.
module tb_s2p_onehot_rx;

  localparam int SS   = 2;
  localparam int HOLD = SS + 2;
`ifdef S2P_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl4, sda4, scl6, sda6;
  logic [15:0] out4;
  logic [63:0] out6;
  logic        valid4, frame_err4, busy4;
  logic        valid6, frame_err6, busy6;

  always #5 clk = ~clk;

  s2p_onehot_rx #(.DATA_W(4), .SYNC_STAGES(SS)) dut4 (
    .clk(clk), .rst_n(rst_n), .scl(scl4), .sda(sda4),
    .out_onehot(out4), .valid(valid4), .frame_err(frame_err4), .busy(busy4)
  );

  s2p_onehot_rx #(.DATA_W(6), .SYNC_STAGES(SS)) dut6 (
    .clk(clk), .rst_n(rst_n), .scl(scl6), .sda(sda6),
    .out_onehot(out6), .valid(valid6), .frame_err(frame_err6), .busy(busy6)
  );

  typedef struct {
    logic [7:0]  bits;
    int          n;
    logic        err;
    logic [15:0] word;
  } vec_t;

  typedef struct {
    logic        err;
    logic [63:0] word;
  } exp_t;

  vec_t tab [7];
  exp_t q4[$];
  exp_t q6[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_v6_cyc = 0;
  int   cyc0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // One clock step; output events are popped from the scoreboard here.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (valid4 || frame_err4) begin
        n_chk++;
        if (q4.size() == 0) begin
          n_fail++;
          $display("FAIL dut4_unexpected: valid=%b frame_err=%b out=%h, required no event",
                   valid4, frame_err4, out4);
        end else begin
          e = q4.pop_front();
          if ({valid4, frame_err4} !== {!e.err, e.err} || out4 !== e.word[15:0]) begin
            n_fail++;
            $display("FAIL dut4_event: valid=%b frame_err=%b out=%h, required valid=%b frame_err=%b out=%h",
                     valid4, frame_err4, out4, !e.err, e.err, e.word[15:0]);
          end
        end
      end
      if (valid6 || frame_err6) begin
        n_chk++;
        if (valid6) last_v6_cyc = cyc;
        if (q6.size() == 0) begin
          n_fail++;
          $display("FAIL dut6_unexpected: valid=%b frame_err=%b out=%h, required no event",
                   valid6, frame_err6, out6);
        end else begin
          e = q6.pop_front();
          if ({valid6, frame_err6} !== {!e.err, e.err} || out6 !== e.word) begin
            n_fail++;
            $display("FAIL dut6_event: valid=%b frame_err=%b out=%h, required valid=%b frame_err=%b out=%h",
                     valid6, frame_err6, out6, !e.err, e.err, e.word);
          end
        end
      end
    end
  endtask

  task automatic pin(input int d, input logic c, input logic s);
    if (d == 0) begin
      scl4 = c;
      sda4 = s;
    end else begin
      scl6 = c;
      sda6 = s;
    end
    repeat (HOLD) tick();
  endtask

  // Data set while scl is low; scl rises together with sda returning low so
  // every bit ends at scl=1/sda=0, from where a stop is a plain sda rise.
  task automatic bitp(input int d, input logic b);
    pin(d, 1'b0, 1'b0);
    pin(d, 1'b0, b);
    pin(d, 1'b1, 1'b0);
  endtask

  task automatic send(input int d, input logic [7:0] bits, input int n);
    pin(d, 1'b1, 1'b0);
    for (int i = n - 1; i >= 0; i--) bitp(d, bits[i]);
  endtask

  task automatic frame(input int d, input logic [7:0] bits, input int n);
    send(d, bits, n);
    pin(d, 1'b1, 1'b1);
  endtask

  initial begin
`ifdef S2P_PARITY_EN
    tab[0] = '{8'b00011,  5, 1'b0, 16'h0001};
    tab[1] = '{8'b00000,  5, 1'b0, 16'h8000};
    tab[2] = '{8'b01111,  5, 1'b0, 16'h0040};
    tab[3] = '{8'b01110,  5, 1'b1, 16'h0040};
    tab[4] = '{8'b11110,  5, 1'b0, 16'h4000};
    tab[5] = '{8'b1111,   4, 1'b1, 16'h4000};
    tab[6] = '{8'b111100, 6, 1'b1, 16'h4000};
`else
    tab[0] = '{8'b0001,  4, 1'b0, 16'h0001};
    tab[1] = '{8'b0000,  4, 1'b0, 16'h8000};
    tab[2] = '{8'b1111,  4, 1'b0, 16'h4000};
    tab[3] = '{8'b1010,  4, 1'b0, 16'h0200};
    tab[4] = '{8'b101,   3, 1'b1, 16'h0200};
    tab[5] = '{8'b10110, 5, 1'b1, 16'h0200};
    tab[6] = '{8'b0011,  4, 1'b0, 16'h0004};
`endif

    rst_n = 1'b0;
    scl4 = 1'b1; sda4 = 1'b1; scl6 = 1'b1; sda6 = 1'b1;
    repeat (3) tick();
    check("rst_out4", 64'(out4), 64'h0);
    check("rst_valid4", 64'(valid4), 64'h0);
    check("rst_ferr4", 64'(frame_err4), 64'h0);
    check("rst_busy4", 64'(busy4), 64'h0);
    check("rst_out6", out6, 64'h0);
    rst_n = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 7; i++) begin
      q4.push_back('{err: tab[i].err, word: 64'(tab[i].word)});
      frame(0, tab[i].bits, tab[i].n);
    end

    // Repeated start after two bits, then a full 0011 frame.
    q4.push_back('{err: 1'b0, word: 64'h0004});
    pin(0, 1'b1, 1'b0);
    bitp(0, 1'b1);
    bitp(0, 1'b0);
    pin(0, 1'b0, 1'b0);
    pin(0, 1'b0, 1'b1);
    pin(0, 1'b1, 1'b1);
    pin(0, 1'b1, 1'b0);
    for (int i = 3 + P; i >= 0; i--) begin
      logic [7:0] rb;
      rb = 8'(4'b0011) << P;
      bitp(0, rb[i]);
    end
    pin(0, 1'b1, 1'b1);
    check("rs_out4", 64'(out4), 64'h0004);

    // Asynchronous reset in the middle of a frame.
    pin(0, 1'b1, 1'b0);
    bitp(0, 1'b1);
    bitp(0, 1'b1);
    check("mid_busy4", 64'(busy4), 64'h1);
    pin(0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_busy4", 64'(busy4), 64'h0);
    check("arst_out4", 64'(out4), 64'h0);
    check("arst_valid4", 64'(valid4), 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    bitp(0, 1'b1);
    bitp(0, 1'b0);
    pin(0, 1'b1, 1'b1);
    check("post_rst_out4", 64'(out4), 64'h0);
    check("post_rst_busy4", 64'(busy4), 64'h0);

    // DATA_W=6: code 0 -> bit 63, code 33 -> bit 32 with stop latency.
    q6.push_back('{err: 1'b0, word: 64'h8000_0000_0000_0000});
    frame(1, 8'h00, 6 + P);
    q6.push_back('{err: 1'b0, word: 64'h0000_0001_0000_0000});
    send(1, 8'(6'd33) << P, 6 + P);
    cyc0 = cyc;
    pin(1, 1'b1, 1'b1);
    check("lat6", 64'(last_v6_cyc - cyc0), 64'(SS + 1));
    check("out6_hold", out6, 64'h0000_0001_0000_0000);

    repeat (10) tick();
    check("q4_drained", 64'(q4.size()), 64'h0);
    check("q6_drained", 64'(q6.size()), 64'h0);
    check("end_busy4", 64'(busy4), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
